alu_sequencer: RTL

//  Owns the accumulator (AC) and sequences the 8-bit ALU for one command stream.

---
 rtl/alu_sequencer_pkg.sv | 26 ++
 rtl/alu_sequencer.sv | 102 ++++++++++
 2 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared opcode codes and sequencer state encodings for the ALU sequencer.
// Imported by the sequencer and by decode logic that issues ALU commands.
package alu_sequencer_pkg;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_INC = 4'd6;
  localparam logic [3:0] OP_CLR = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_LD  = 4'd9;
  localparam logic [3:0] OP_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op != 4'd0) && (op <= OP_MAX);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Accumulator owner that sequences the external 8-bit ALU per command.
// Optional zero flag output enabled by defining ALU_SEQ_ZFLAG_EN.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [7:0] AC_RESET      = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic [6:0]  alus,
  output logic [15:0] bus_out,
  output logic [7:0]  ac,
  input  logic [7:0]  alu_dout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
`ifdef ALU_SEQ_ZFLAG_EN
  output logic        rsp_err,
  output logic        zflag
`else
  output logic        rsp_err
`endif
);

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     nxt;
  logic [3:0] cnt;
  logic       acc;
  logic       legal;
  logic       done;

  assign cmd_ready = (state == IDLE);
  assign acc       = cmd_valid && (state == IDLE);
  assign legal     = op_legal(cmd_op);
  assign done      = (state == EXEC) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (acc) nxt = legal ? EXEC : RESP;
      EXEC: if (done) nxt = RESP;
      RESP: if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // alus/bus are registered so the ALU sees a glitch-free select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac        <= AC_RESET;
      alus      <= 7'd0;
      bus_out   <= 16'h0;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_err   <= 1'b0;
    end else begin
      if (acc && legal) begin
        alus    <= {3'b000, cmd_op};
        bus_out <= {8'h00, cmd_data};
        cnt     <= 4'd0;
      end
      if (acc && !legal) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_data  <= ac;
      end
      if (state == EXEC) begin
        cnt <= cnt + 4'd1;
        if (done) begin
          ac        <= alu_dout;
          rsp_data  <= alu_dout;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          alus      <= 7'd0;
          bus_out   <= 16'h0;
        end
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_SEQ_ZFLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    zflag <= 1'b0;
    else if (done) zflag <= (alu_dout == 8'h00);
  end
`endif

endmodule
